// File: rtl/multimode_ff_reg.sv
// Bank of WIDTH flip-flops whose next-state function (D, T, JK or SR) is picked per cycle by mode.
// Also tracks which bits changed on the last edge and records sticky SR S=R=1 violations.
module multimode_ff_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] toggled,
    output logic             sr_err,
    output logic [WIDTH-1:0] sr_err_mask
);

    localparam logic [1:0] MODE_D  = 2'b00;
    localparam logic [1:0] MODE_T  = 2'b01;
    localparam logic [1:0] MODE_JK = 2'b10;
    localparam logic [1:0] MODE_SR = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] toggled_q, toggled_d;
    logic             sr_err_q, sr_err_d;
    logic [WIDTH-1:0] sr_err_mask_q, sr_err_mask_d;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] viol;

    // Per-bit next state; SR with S=R=1 holds the bit and is reported separately.
    always_comb begin
        q_next = q_q;
        unique case (mode)
            MODE_D:  q_next = a;
            MODE_T:  q_next = q_q ^ a;
            MODE_JK: q_next = (a & ~q_q) | (~b & q_q);
            MODE_SR: q_next = (a & ~b) | (q_q & ~(a ^ b)) | (q_q & a & b);
            default: q_next = q_q;
        endcase
    end

    // en gates every update, so X on a/b while disabled never reaches the state.
    always_comb begin
        q_d           = q_q;
        toggled_d     = '0;
        viol          = '0;
        if (en) begin
            q_d       = q_next;
            toggled_d = q_next ^ q_q;
            if (mode == MODE_SR) viol = a & b;
        end
        if (err_clr) begin
            sr_err_d      = |viol;
            sr_err_mask_d = viol;
        end else begin
            sr_err_d      = sr_err_q | (|viol);
            sr_err_mask_d = sr_err_mask_q | viol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q           <= RESET_VAL;
            toggled_q     <= '0;
            sr_err_q      <= 1'b0;
            sr_err_mask_q <= '0;
        end else begin
            q_q           <= q_d;
            toggled_q     <= toggled_d;
            sr_err_q      <= sr_err_d;
            sr_err_mask_q <= sr_err_mask_d;
        end
    end

    assign q           = q_q;
    assign q_bar       = ~q_q;
    assign toggled     = toggled_q;
    assign sr_err      = sr_err_q;
    assign sr_err_mask = sr_err_mask_q;

endmodule

// File: tb/tb_multimode_ff_reg.sv
// Directed bench for multimode_ff_reg with WIDTH=4, RESET_VAL=4'b1010.
module tb_multimode_ff_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic       err_clr;
    logic [3:0] q;
    logic [3:0] q_bar;
    logic [3:0] toggled;
    logic       sr_err;
    logic [3:0] sr_err_mask;

    int total = 0;
    int bad   = 0;

    multimode_ff_reg #(
        .WIDTH     (4),
        .RESET_VAL (4'b1010)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .a           (a),
        .b           (b),
        .err_clr     (err_clr),
        .q           (q),
        .q_bar       (q_bar),
        .toggled     (toggled),
        .sr_err      (sr_err),
        .sr_err_mask (sr_err_mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] eq, input logic [3:0] etog,
                               input logic eerr, input logic [3:0] emask);
        check({tag, ".q"}, q, eq);
        check({tag, ".q_bar"}, q_bar, ~eq);
        check({tag, ".toggled"}, toggled, etog);
        check({tag, ".sr_err"}, {3'b000, sr_err}, {3'b000, eerr});
        check({tag, ".mask"}, sr_err_mask, emask);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; mode = 2'b01; a = 4'b1111; b = 4'b1111; err_clr = 1'b0;
        step();
        check_state("reset", 4'b1010, 4'b0000, 1'b0, 4'b0000);

        rst = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_state("idle", 4'b1010, 4'b0000, 1'b0, 4'b0000);
        end

        // D then T
        en = 1'b1; mode = 2'b00; a = 4'b0110; b = 4'b0000;
        step();
        check_state("d", 4'b0110, 4'b1100, 1'b0, 4'b0000);
        mode = 2'b01; a = 4'b0011;
        step();
        check_state("t1", 4'b0101, 4'b0011, 1'b0, 4'b0000);
        step();
        check_state("t2", 4'b0110, 4'b0011, 1'b0, 4'b0000);

        // JK: bit3 toggle, bit2 set, bit1 clear, bit0 hold
        mode = 2'b00; a = 4'b0000;
        step();
        check_state("jk_pre", 4'b0000, 4'b0110, 1'b0, 4'b0000);
        mode = 2'b10; a = 4'b1100; b = 4'b1010;
        step();
        check_state("jk1", 4'b1100, 4'b1100, 1'b0, 4'b0000);
        step();
        check_state("jk2", 4'b0100, 4'b1000, 1'b0, 4'b0000);

        // SR: bit3 set, bit2 hold, bit1 clear, bit0 violation holds 1
        mode = 2'b00; a = 4'b0101; b = 4'b0000;
        step();
        check_state("sr_pre", 4'b0101, 4'b0001, 1'b0, 4'b0000);
        mode = 2'b11; a = 4'b1001; b = 4'b0011;
        step();
        check_state("sr_viol", 4'b1101, 4'b1000, 1'b1, 4'b0001);
        a = 4'b0000; b = 4'b0000;
        step();
        check_state("sr_sticky1", 4'b1101, 4'b0000, 1'b1, 4'b0001);
        step();
        check_state("sr_sticky2", 4'b1101, 4'b0000, 1'b1, 4'b0001);

        // err_clr colliding with a new violation: new bits replace old ones
        err_clr = 1'b1; a = 4'b0100; b = 4'b0100;
        step();
        check_state("clr_coll", 4'b1101, 4'b0000, 1'b1, 4'b0100);
        a = 4'b0000; b = 4'b0000;
        step();
        check_state("clr", 4'b1101, 4'b0000, 1'b0, 4'b0000);

        // Violations accumulate without err_clr
        err_clr = 1'b0; a = 4'b0001; b = 4'b0001;
        step();
        check_state("acc1", 4'b1101, 4'b0000, 1'b1, 4'b0001);
        a = 4'b1000; b = 4'b1000;
        step();
        check_state("acc2", 4'b1101, 4'b0000, 1'b1, 4'b1001);
        err_clr = 1'b1; a = 4'b0000; b = 4'b0000;
        step();
        check_state("clr2", 4'b1101, 4'b0000, 1'b0, 4'b0000);
        err_clr = 1'b0;

        // Enable gating: no update, no error, X inputs ignored
        en = 1'b0; mode = 2'b11; a = 4'b1111; b = 4'b1111;
        step();
        check_state("gate_sr", 4'b1101, 4'b0000, 1'b0, 4'b0000);
        mode = 2'b01; a = 4'bxxxx; b = 4'bxxxx;
        step();
        check_state("gate_x", 4'b1101, 4'b0000, 1'b0, 4'b0000);

        // Reset beats an enabled T-mode update
        en = 1'b1; mode = 2'b01; a = 4'b1111; b = 4'b0000; rst = 1'b1;
        step();
        check_state("rst_mid", 4'b1010, 4'b0000, 1'b0, 4'b0000);
        rst = 1'b0; en = 1'b0;
        step();
        check_state("post_rst", 4'b1010, 4'b0000, 1'b0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
